// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 64K x 8 memory between the CPU port and a
// DMA/video port. One access runs at a time (IDLE -> ACCESS -> IDLE). The CPU has
// fixed priority, but after MAX_CPU_RUN consecutive CPU grants with DMA waiting,
// the DMA port wins the next arbitration.
//
// Handshake: a requester raises req and holds it (with we/address/wdata stable)
// until it sees ack. ack is a one-cycle pulse and rdata is valid while ack is high
// (and held afterwards). Requester inputs are only sampled in IDLE, so dropping
// req mid-access does not cancel the access. A port whose ack is high is ignored
// for that cycle so it is not granted twice while it drops req.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int READ_LAT    = 0,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic [7:0]        dma_wdata,
    output logic [7:0]        dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_o_data,
    output logic              mem_wren,
    input  logic [7:0]        mem_i_data,
    output logic              owner
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACCESS = 1'b1;
    localparam logic [1:0] LAT_LAST = 2'(READ_LAT);
    localparam logic [3:0] RUN_MAX  = 4'(MAX_CPU_RUN);

    logic              state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [3:0]        run_q, run_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [7:0]        mem_o_data_q, mem_o_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              owner_q, owner_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        dma_rdata_q, dma_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;

    logic cpu_elig;
    logic dma_elig;
    logic pick_dma;

    // Eligibility and winner selection (only meaningful in IDLE)
    always_comb begin
        cpu_elig = cpu_req & ~cpu_ack_q;
        dma_elig = dma_req & ~dma_ack_q;
        pick_dma = dma_elig & (~cpu_elig | (run_q == RUN_MAX));
    end

    // Next-state logic for the access FSM, run counter and output registers
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        run_d         = run_q;
        mem_address_d = mem_address_q;
        mem_o_data_d  = mem_o_data_q;
        mem_wren_d    = 1'b0;
        owner_d       = owner_q;
        cpu_rdata_d   = cpu_rdata_q;
        dma_rdata_d   = dma_rdata_q;
        cpu_ack_d     = 1'b0;
        dma_ack_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_elig || dma_elig) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 2'd0;
                    owner_d = pick_dma;
                    if (pick_dma) begin
                        mem_address_d = dma_address;
                        mem_o_data_d  = dma_wdata;
                        mem_wren_d    = dma_we;
                        run_d         = 4'd0;
                    end else begin
                        mem_address_d = cpu_address;
                        mem_o_data_d  = cpu_wdata;
                        mem_wren_d    = cpu_we;
                        if (dma_elig) begin
                            run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 4'd1;
                        end else begin
                            run_d = 4'd0;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                // Write enable only ever spans the first access cycle
                if (cnt_q == LAT_LAST) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        dma_rdata_d = mem_i_data;
                        dma_ack_d   = 1'b1;
                    end else begin
                        cpu_rdata_d = mem_i_data;
                        cpu_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; async reset drops any in-flight access and its write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 2'd0;
            run_q         <= 4'd0;
            mem_address_q <= '0;
            mem_o_data_q  <= 8'd0;
            mem_wren_q    <= 1'b0;
            owner_q       <= 1'b0;
            cpu_rdata_q   <= 8'd0;
            dma_rdata_q   <= 8'd0;
            cpu_ack_q     <= 1'b0;
            dma_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            run_q         <= run_d;
            mem_address_q <= mem_address_d;
            mem_o_data_q  <= mem_o_data_d;
            mem_wren_q    <= mem_wren_d;
            owner_q       <= owner_d;
            cpu_rdata_q   <= cpu_rdata_d;
            dma_rdata_q   <= dma_rdata_d;
            cpu_ack_q     <= cpu_ack_d;
            dma_ack_q     <= dma_ack_d;
        end
    end

    assign mem_address = mem_address_q;
    assign mem_o_data  = mem_o_data_q;
    assign mem_wren    = mem_wren_q;
    assign owner       = owner_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dma_rdata   = dma_rdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign dma_ack     = dma_ack_q;

endmodule
